// File: rtl/C.sv
// Shared core configuration: architectural width and instruction-memory defaults
// used as parameter defaults by the fetch responder.
package C;
  localparam int              XLEN            = 32;
  localparam int              FETCH_RSP_DEPTH = 4;
  localparam logic [XLEN-1:0] IMEM_BASE       = 32'h8000_0000;
  localparam int              IMEM_WORDS      = 16384;
endpackage

// File: rtl/fetch_rsp_fifo.sv
// Parameterised synchronous FIFO with combinational head read and wrap-bit
// pointers so full and empty are distinguishable for any DEPTH.
module fetch_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic             wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;

  assign empty    = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
  assign full     = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
  assign pop_data = mem_q[rd_idx_q];

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_wrap_d = wr_wrap_q;
    rd_idx_d  = rd_idx_q;
    rd_wrap_d = rd_wrap_q;
    if (push) begin
      if (wr_idx_q == LAST) begin
        wr_idx_d  = '0;
        wr_wrap_d = ~wr_wrap_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    if (pop) begin
      if (rd_idx_q == LAST) begin
        rd_idx_d  = '0;
        rd_wrap_d = ~rd_wrap_q;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_idx_q  <= '0;
      rd_wrap_q <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_wrap_q <= wr_wrap_d;
      rd_idx_q  <= rd_idx_d;
      rd_wrap_q <= rd_wrap_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx_q] <= push_data;
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  assert property (@(posedge clk) disable iff (rst) !(pop && empty));
endmodule

// File: rtl/fetch_responder.sv
// Instruction fetch responder: credit-limited, in-order return of 32-bit words
// from a synchronous memory. Optional LFSR back-pressure: FETCH_RSP_STALL_EN.
module fetch_responder
  import C::*;
#(
  parameter int              DEPTH     = FETCH_RSP_DEPTH,
  parameter logic [XLEN-1:0] MEM_BASE  = IMEM_BASE,
  parameter int              MEM_WORDS = IMEM_WORDS,
  localparam int             IDXW      = $clog2(MEM_WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_addr_valid,
  output logic            fetch_addr_ready,
  input  logic [XLEN-1:0] fetch_addr,
  output logic            fetch_data_valid,
  output logic [31:0]     fetch_data,
  input  logic            fetch_data_ready,
  output logic            mem_req_o,
  output logic [IDXW-1:0] mem_idx_o,
  input  logic [31:0]     mem_rdata_i
);
  localparam int            CW        = $clog2(DEPTH + 1);
  localparam logic [XLEN:0] MEM_BYTES = (XLEN + 1)'(MEM_WORDS) << 2;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_vld_q, pend_vld_d;
  logic            pend_oob_q, pend_oob_d;
  logic            stall_addr, stall_data;
  logic            addr_fire, data_fire, in_range;
  logic [XLEN-1:0] offset;
  logic [31:0]     push_data, head_data;
  logic            fifo_full, fifo_empty;

`ifdef FETCH_RSP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps 16,14,13,11 shifting toward the MSB.
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign stall_addr = lfsr_q[0];
  assign stall_data = lfsr_q[1];
`else
  assign stall_addr = 1'b0;
  assign stall_data = 1'b0;
`endif

  assign fetch_addr_ready = !rst && (cnt_q < CW'(DEPTH)) && !stall_addr;
  assign addr_fire        = fetch_addr_valid && fetch_addr_ready;

  // Offset compare avoids overflow when the window sits near the top of the space.
  assign offset   = fetch_addr - MEM_BASE;
  assign in_range = (fetch_addr >= MEM_BASE) && ({1'b0, offset} < MEM_BYTES);

  assign mem_req_o = addr_fire && in_range;
  assign mem_idx_o = mem_req_o ? offset[IDXW+1:2] : '0;

  assign fetch_data_valid = !rst && !fifo_empty && !stall_data;
  assign fetch_data       = rst ? 32'h0 : head_data;
  assign data_fire        = fetch_data_valid && fetch_data_ready;

  assign push_data = pend_oob_q ? 32'h0000_0000 : mem_rdata_i;

  always_comb begin
    pend_vld_d = addr_fire;
    pend_oob_d = addr_fire && !in_range;
    cnt_d      = cnt_q;
    if (addr_fire && !data_fire)      cnt_d = cnt_q + 1'b1;
    else if (!addr_fire && data_fire) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_oob_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_oob_q <= pend_oob_d;
    end
  end

  fetch_rsp_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pend_vld_q),
    .push_data(push_data),
    .pop      (data_fire),
    .pop_data (head_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assert property (@(posedge clk) disable iff (rst) cnt_q <= CW'(DEPTH));
  assert property (@(posedge clk) disable iff (rst) !(fifo_full && pend_vld_q && !data_fire));
endmodule

// File: tb/tb_fetch_responder.sv
// Directed bench for fetch_responder: vector table of single fetches plus
// sequences for streaming, back-pressure, mid-operation reset and ordering.
module tb_fetch_responder;
  import C::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_addr_valid;
  logic            fetch_addr_ready;
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_data_valid;
  logic [31:0]     fetch_data;
  logic            fetch_data_ready;
  logic            mem_req;
  logic [13:0]     mem_idx;
  logic [31:0]     mem_rdata;

  logic [31:0] mem [16384];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_responder dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_addr_valid(fetch_addr_valid),
    .fetch_addr_ready(fetch_addr_ready),
    .fetch_addr      (fetch_addr),
    .fetch_data_valid(fetch_data_valid),
    .fetch_data      (fetch_data),
    .fetch_data_ready(fetch_data_ready),
    .mem_req_o       (mem_req),
    .mem_idx_o       (mem_idx),
    .mem_rdata_i     (mem_rdata)
  );

  // Synchronous memory; garbage when not strobed so a missing request is visible.
  always @(posedge clk) mem_rdata <= mem_req ? mem[mem_idx] : 32'hDEAD_BEEF;

  function automatic logic [31:0] word_of(input int i);
    return (i == 0) ? 32'h0000_0013 : (32'h1000_0000 | 32'(i * 7));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        req;
    logic [13:0] idx;
    logic [31:0] data;
  } vec_t;

  vec_t vt[8];
  int acc, issued, got, cyc, a_stall, d_stall;

  initial begin
    vt[0] = '{32'h8000_0000, 1'b1, 14'd0,     32'h0000_0013};
    vt[1] = '{32'h8000_0004, 1'b1, 14'd1,     32'h1000_0007};
    vt[2] = '{32'h8000_FFFC, 1'b1, 14'd16383, 32'h1001_BFF9};
    vt[3] = '{32'h8000_0123, 1'b1, 14'd72,    32'h1000_01F8};
    vt[4] = '{32'h7FFF_FFFC, 1'b0, 14'd0,     32'h0000_0000};
    vt[5] = '{32'h8001_0000, 1'b0, 14'd0,     32'h0000_0000};
    vt[6] = '{32'h0000_0000, 1'b0, 14'd0,     32'h0000_0000};
    vt[7] = '{32'hFFFF_FFFC, 1'b0, 14'd0,     32'h0000_0000};
    for (int i = 0; i < 16384; i++) mem[i] = word_of(i);

    rst = 1'b1;
    fetch_addr_valid = 1'b0;
    fetch_addr = '0;
    fetch_data_ready = 1'b1;

    // Reset state, with an in-range address offered to prove nothing leaks through.
    @(negedge clk);
    fetch_addr_valid = 1'b1;
    fetch_addr = 32'h8000_0010;
    #1;
    check("rst_addr_ready", 32'(fetch_addr_ready), 32'd0);
    check("rst_data_valid", 32'(fetch_data_valid), 32'd0);
    check("rst_data", fetch_data, 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_idx", 32'(mem_idx), 32'd0);
    @(negedge clk);
    fetch_addr_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(fetch_addr_ready), 32'd1);
    check("post_rst_cnt", 32'(dut.cnt_q), 32'd0);
    check("post_rst_valid", 32'(fetch_data_valid), 32'd0);

    // Single fetches from the table: request in N, data valid in N+2, then drained.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fetch_addr_valid = 1'b1;
      fetch_addr = vt[i].addr;
      #1;
      check($sformatf("v%0d_ready", i), 32'(fetch_addr_ready), 32'd1);
      check($sformatf("v%0d_req", i), 32'(mem_req), 32'(vt[i].req));
      if (vt[i].req) check($sformatf("v%0d_idx", i), 32'(mem_idx), 32'(vt[i].idx));
      @(negedge clk);
      fetch_addr_valid = 1'b0;
      #1;
      check($sformatf("v%0d_n1_valid", i), 32'(fetch_data_valid), 32'd0);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_n2_valid", i), 32'(fetch_data_valid), 32'd1);
      check($sformatf("v%0d_data", i), fetch_data, vt[i].data);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_drained", i), 32'(fetch_data_valid), 32'd0);
    end

    // Eight back-to-back fetches: one word per cycle, ready never drops.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      fetch_addr_valid = (k < 8);
      fetch_addr = 32'h8000_0000 + 32'(4 * k);
      #1;
      if (k < 8) check($sformatf("b2b_ready%0d", k), 32'(fetch_addr_ready), 32'd1);
      if (k >= 2) begin
        check($sformatf("b2b_valid%0d", k - 2), 32'(fetch_data_valid), 32'd1);
        check($sformatf("b2b_data%0d", k - 2), fetch_data, word_of(k - 2));
      end
    end
    @(negedge clk);
    #1;
    check("b2b_idle", 32'(fetch_data_valid), 32'd0);

    // Consumer stalled for 10 cycles: exactly DEPTH accepted, head stable.
    fetch_data_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      fetch_addr_valid = 1'b1;
      fetch_addr = 32'h8000_0400 + 32'(4 * acc);
      #1;
      if (fetch_addr_ready) acc++;
      if (k >= 2) check($sformatf("bp_head%0d", k), fetch_data, word_of(256));
    end
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_ready_low", 32'(fetch_addr_ready), 32'd0);
    check("bp_cnt", 32'(dut.cnt_q), 32'd4);
    check("bp_valid", 32'(fetch_data_valid), 32'd1);
    @(negedge clk);
    fetch_addr_valid = 1'b0;
    fetch_data_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check($sformatf("bp_rel_valid%0d", j), 32'(fetch_data_valid), 32'd1);
      check($sformatf("bp_rel_data%0d", j), fetch_data, word_of(256 + j));
      @(negedge clk);
    end
    #1;
    check("bp_empty", 32'(fetch_data_valid), 32'd0);
    check("bp_cnt_zero", 32'(dut.cnt_q), 32'd0);

    // Reset with three outstanding requests discards them all.
    fetch_data_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      fetch_addr_valid = 1'b1;
      fetch_addr = 32'h8000_0800 + 32'(4 * k);
    end
    @(negedge clk);
    fetch_addr_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_cnt3", 32'(dut.cnt_q), 32'd3);
    rst = 1'b1;
    fetch_addr_valid = 1'b1;
    fetch_addr = 32'h8000_0000;
    #1;
    check("mid_rst_ready", 32'(fetch_addr_ready), 32'd0);
    check("mid_rst_valid", 32'(fetch_data_valid), 32'd0);
    check("mid_rst_data", fetch_data, 32'h0);
    check("mid_rst_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch_addr_valid = 1'b0;
    fetch_data_ready = 1'b1;
    #1;
    check("mid_cnt0", 32'(dut.cnt_q), 32'd0);
    check("mid_valid0", 32'(fetch_data_valid), 32'd0);
    @(negedge clk);
    fetch_addr_valid = 1'b1;
    fetch_addr = 32'h8000_0008;
    #1;
    check("mid_new_req", 32'(mem_req), 32'd1);
    check("mid_new_idx", 32'(mem_idx), 32'd2);
    @(negedge clk);
    fetch_addr_valid = 1'b0;
    #1;
    check("mid_new_n1", 32'(fetch_data_valid), 32'd0);
    @(negedge clk);
    #1;
    check("mid_new_valid", 32'(fetch_data_valid), 32'd1);
    check("mid_new_data", fetch_data, word_of(2));
    @(negedge clk);
    #1;
    check("mid_new_drained", 32'(fetch_data_valid), 32'd0);

    // 100 sequential fetches honouring both handshakes, bounded by a cycle budget.
    issued = 0;
    got = 0;
    cyc = 0;
    a_stall = 0;
    d_stall = 0;
    while (got < 100 && cyc < 2000) begin
      @(negedge clk);
      fetch_addr_valid = (issued < 100);
      fetch_addr = 32'h8000_1000 + 32'(4 * issued);
      #1;
      if (fetch_addr_valid && !fetch_addr_ready && dut.cnt_q < 3'd4) a_stall++;
      if (!fetch_data_valid && (issued - got) >= 2) d_stall++;
      if (fetch_data_valid && fetch_data_ready) begin
        check($sformatf("seq_data%0d", got), fetch_data, word_of(1024 + got));
        got++;
      end
      if (fetch_addr_valid && fetch_addr_ready) issued++;
      cyc++;
    end
    check("seq_received", 32'(got), 32'd100);
    @(negedge clk);
    fetch_addr_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("seq_idle", 32'(fetch_data_valid), 32'd0);
`ifdef FETCH_RSP_STALL_EN
    check("stall_addr_seen", 32'(a_stall > 0), 32'd1);
    check("stall_data_seen", 32'(d_stall > 0), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
